// File: rtl/serial_paralelo_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_paralelo_rx_pkg
// Purpose : Shared PHY definitions for the serial receive path. Holds the
//           COM (alignment/idle) symbol used by both the transmitter's IDL
//           generator and the receiver, plus the receiver FSM state encoding.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package serial_paralelo_rx_pkg;

  // Alignment / idle symbol shared with the transmitter's IDL generator.
  localparam logic [7:0] COM_SYMBOL_DEF = 8'hBC;

  // Receiver FSM encoding.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_t;

  // Bit position within the current byte, wraps 7 -> 0.
  function automatic logic [2:0] bit_cnt_inc(input logic [2:0] cnt);
    return cnt + 3'd1;
  endfunction

endpackage : serial_paralelo_rx_pkg
`default_nettype wire

// File: rtl/serial_paralelo_rx_com_detector.sv
`default_nettype none
// ============================================================================
// Module  : serial_paralelo_rx_com_detector
// Purpose : Bit-serial shift register and COM comparator. Presents the byte
//           completed by the current serial bit (nxt) and flags when that
//           byte equals the COM symbol.
// Ports   : clk_32f  - bit clock
//           reset    - asynchronous, active-low reset
//           data_in  - serial data, MSB first
//           nxt      - {history[6:0], data_in}, the byte ending on this bit
//           is_com   - nxt == COM_SYMBOL
// Rev     : 1.0 - initial release
// ============================================================================
module serial_paralelo_rx_com_detector
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEF
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] nxt,
  output logic       is_com
);

  // Only the seven most recent bits are ever needed: the eighth comes
  // straight from data_in, so the oldest bit of the shift register would
  // never be read.
  logic [6:0] hist;

  assign nxt    = {hist, data_in};
  assign is_com = (nxt == COM_SYMBOL);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      hist <= '0;
    end else begin
      hist <= nxt[6:0];
    end
  end

endmodule : serial_paralelo_rx_com_detector
`default_nettype wire

// File: rtl/serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
// Module  : serial_paralelo_rx
// Purpose : Serial-to-parallel receiver. Bit-slides to find COM (0xBC)
//           alignment, requires COM_COUNT consecutive aligned COMs before
//           declaring the link active, then emits each aligned non-COM byte
//           with a one-cycle valid strobe.
// Ports   : clk_32f   - bit clock, one serial bit per rising edge
//           reset     - asynchronous, active-low reset
//           data_in   - serial data, MSB of each byte first
//           data_out  - last aligned byte received while active
//           valid_out - one-cycle strobe, data_out holds a new non-COM byte
//           active    - link aligned and active
// Config  : `define LOS_DETECT_EN to drop the link after LOS_BYTES
//           consecutive aligned 0x00 bytes. Without it ACTIVE is left only
//           by reset.
// Rev     : 1.0 - initial release
// ============================================================================
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [7:0]  COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int unsigned COM_COUNT  = 4,
  parameter int unsigned LOS_BYTES  = 16
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  // Parameter range checks, evaluated at elaboration.
  if (COM_COUNT < 1 || COM_COUNT > 15) begin : g_bad_com_count
    $error("serial_paralelo_rx: COM_COUNT must be in 1..15");
  end
  if (LOS_BYTES < 1 || LOS_BYTES > 31) begin : g_bad_los_bytes
    $error("serial_paralelo_rx: LOS_BYTES must be in 1..31");
  end

  // --------------------------------------------------------------------------
  // Shift register / COM comparator
  // --------------------------------------------------------------------------
  logic [7:0] nxt;
  logic       is_com;

  serial_paralelo_rx_com_detector #(
    .COM_SYMBOL (COM_SYMBOL)
  ) u_com_detector (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .nxt     (nxt),
    .is_com  (is_com)
  );

  // --------------------------------------------------------------------------
  // State and next-state signals
  // --------------------------------------------------------------------------
  rx_state_t  state,     state_n;
  logic [2:0] bit_cnt,   bit_cnt_n;
  logic [3:0] com_cnt,   com_cnt_n;
  logic [7:0] data_n;
  logic       valid_n;
  logic       active_n;
  logic [3:0] com_cnt_inc;

  assign com_cnt_inc = com_cnt + 4'd1;

`ifdef LOS_DETECT_EN
  localparam logic [4:0] LOS_TARGET = 5'(LOS_BYTES);
  logic [4:0] zero_cnt, zero_cnt_n;
  logic [4:0] zero_cnt_inc;
  assign zero_cnt_inc = zero_cnt + 5'd1;
`endif

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= ST_SEARCH;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
`ifdef LOS_DETECT_EN
      zero_cnt  <= '0;
`endif
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      com_cnt   <= com_cnt_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      active    <= active_n;
`ifdef LOS_DETECT_EN
      zero_cnt  <= zero_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    com_cnt_n  = com_cnt;
    data_n     = data_out;
    valid_n    = 1'b0;
`ifdef LOS_DETECT_EN
    zero_cnt_n = zero_cnt;
`endif

    unique case (state)
      // Bit-sliding search: every cycle is a candidate byte boundary.
      ST_SEARCH: begin
        bit_cnt_n = 3'd0;
        if (is_com) begin
          com_cnt_n = 4'd1;
          state_n   = (COM_TARGET == 4'd1) ? ST_ACTIVE : ST_COUNT;
        end
      end

      // Alignment candidate found; confirm with further COMs on the same
      // byte grid. A miss restarts the search on the next cycle.
      ST_COUNT: begin
        bit_cnt_n = bit_cnt_inc(bit_cnt);
        if (bit_cnt == 3'd7) begin
          if (is_com) begin
            if (com_cnt_inc >= COM_TARGET) begin
              com_cnt_n = COM_TARGET;
              state_n   = ST_ACTIVE;
            end else begin
              com_cnt_n = com_cnt_inc;
            end
          end else begin
            com_cnt_n = 4'd0;
            state_n   = ST_SEARCH;
          end
        end
      end

      ST_ACTIVE: begin
        bit_cnt_n = bit_cnt_inc(bit_cnt);
        if (bit_cnt == 3'd7) begin
          data_n  = nxt;
          valid_n = !is_com;
`ifdef LOS_DETECT_EN
          if (nxt == 8'h00) begin
            if (zero_cnt_inc == LOS_TARGET) begin
              valid_n   = 1'b0;
              com_cnt_n = 4'd0;
              bit_cnt_n = 3'd0;
              state_n   = ST_SEARCH;
            end else begin
              zero_cnt_n = zero_cnt_inc;
            end
          end else begin
            zero_cnt_n = 5'd0;
          end
`endif
        end
      end

      default: begin
        state_n   = ST_SEARCH;
        bit_cnt_n = 3'd0;
        com_cnt_n = 4'd0;
      end
    endcase

    // active is registered so it changes on the same edge as the state.
    active_n = (state_n == ST_ACTIVE);

`ifdef LOS_DETECT_EN
    if (state_n != ST_ACTIVE) begin
      zero_cnt_n = 5'd0;
    end
`endif
  end

endmodule : serial_paralelo_rx
`default_nettype wire
